// File: rtl/temp_spi_rd.sv
// Periodic SPI (mode 0) reader for a 13-bit two's complement temperature sensor.
// Converts each well-formed 16-bit frame into an unsigned integer degC plus a 1/16 degC nibble.
module temp_spi_rd #(
  parameter int CLK_DIV       = 50,
  parameter int CS_SETUP      = 4,
  parameter int SAMPLE_PERIOD = 25_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       miso_i,
  output logic       cs_n_o,
  output logic       sck_o,
  output logic [7:0] temp_c_o,
  output logic [3:0] temp_frac_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int CMAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);
  localparam int TW   = ($clog2(SAMPLE_PERIOD) < 1) ? 1 : $clog2(SAMPLE_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_PROCESS
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] frame_q, frame_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic [7:0]  temp_c_q, temp_c_d;
  logic [3:0]  temp_frac_q, temp_frac_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic setup_done, phase_done, trigger;

  // Free-running sample timer; frame start cadence does not depend on frame outcome.
  assign tmr_d      = (tmr_q == TW'(SAMPLE_PERIOD - 1)) ? '0 : tmr_q + TW'(1);
  assign trigger    = (tmr_q == '0);
  assign setup_done = (cnt_q == CW'(CS_SETUP - 1));
  assign phase_done = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    temp_c_d    = temp_c_q;
    temp_frac_d = temp_frac_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (!phase_done) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            // Capture on the same edge that raises sck, MSB first.
            sck_d   = 1'b1;
            frame_d = {frame_q[14:0], miso_i};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 4'd15) state_d = S_HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (phase_done) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = S_PROCESS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PROCESS: begin
        state_d = S_IDLE;
        // Nonzero pad bits flag a bad frame (an absent sensor reads all ones).
        if (frame_q[2:0] != 3'b000) begin
          err_d = 1'b1;
        end else begin
          err_d   = 1'b0;
          valid_d = 1'b1;
          if (frame_q[15]) begin
            temp_c_d    = '0;
            temp_frac_d = '0;
          end else begin
            temp_c_d    = frame_q[14:7];
            temp_frac_d = frame_q[6:3];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      temp_c_q    <= '0;
      temp_frac_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      temp_c_q    <= temp_c_d;
      temp_frac_q <= temp_frac_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign cs_n_o      = cs_n_q;
  assign sck_o       = sck_q;
  assign temp_c_o    = temp_c_q;
  assign temp_frac_o = temp_frac_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_temp_spi_rd.sv
// Directed bench for temp_spi_rd: table of sensor frames plus reset corner cases.
module tb_temp_spi_rd;

  localparam int CLK_DIV = 2;
  localparam int CS_SETUP = 4;
  localparam int SAMPLE_PERIOD = 200;
  localparam int BUDGET = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       miso = 1'b1;
  logic       cs_n, sck, valid, err, busy;
  logic [7:0] temp_c;
  logic [3:0] temp_frac;

  temp_spi_rd #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .SAMPLE_PERIOD(SAMPLE_PERIOD)) dut (
    .clk_i(clk), .rst_i(rst), .miso_i(miso), .cs_n_o(cs_n), .sck_o(sck),
    .temp_c_o(temp_c), .temp_frac_o(temp_frac), .valid_o(valid), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: loads its word when selected, presents MSB, advances on each sck fall.
  logic [15:0] next_frame = 16'hFFFF;
  logic [15:0] sens = 16'hFFFF;
  logic        prev_cs = 1'b1, prev_sck = 1'b0;
  always @(negedge clk) begin
    if (prev_cs && !cs_n) sens = next_frame;
    else if (!cs_n && prev_sck && !sck) sens = {sens[14:0], 1'b1};
    miso = cs_n ? 1'b1 : sens[15];
    prev_cs = cs_n;
    prev_sck = sck;
  end

  int passed = 0, total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  c;
    logic [3:0]  f;
    logic        v;
    logic        e;
  } vec_t;

  // Runs (or finishes, if cs_n is already low) one frame and checks all timing and results.
  task automatic run_frame(input vec_t t, input string nm, output int start);
    int n, lowc, rises, first;
    logic psck;
    n = 0;
    while (cs_n !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    check({nm, " start"}, cs_n, 0);
    start = cyc;
    check({nm, " busy_rise"}, busy, 1);
    lowc = 0; rises = 0; first = 0; psck = 1'b0;
    while (cs_n === 1'b0 && lowc < BUDGET) begin
      lowc++;
      if (sck && !psck) begin rises++; if (rises == 1) first = lowc; end
      psck = sck;
      @(negedge clk);
    end
    check({nm, " cs_low"}, lowc, CS_SETUP + 33 * CLK_DIV);
    check({nm, " sck_rises"}, rises, 16);
    check({nm, " first_rise"}, first, CS_SETUP + CLK_DIV + 1);
    check({nm, " proc_valid"}, valid, 0);
    check({nm, " proc_busy"}, busy, 1);
    @(negedge clk);
    check({nm, " valid"}, valid, t.v);
    check({nm, " busy_fall"}, busy, 0);
    check({nm, " temp_c"}, temp_c, t.c);
    check({nm, " temp_frac"}, temp_frac, t.f);
    check({nm, " err"}, err, t.e);
    @(negedge clk);
    check({nm, " valid_once"}, valid, 0);
  endtask

  vec_t tbl[7];
  vec_t mid;

  initial begin
    int start, prev, rel, n, r;
    logic psck;
    tbl[0] = '{16'h0C80, 8'd25,  4'd0,  1'b1, 1'b0};
    tbl[1] = '{16'h0D08, 8'd26,  4'd1,  1'b1, 1'b0};
    tbl[2] = '{16'h7FF8, 8'd255, 4'd15, 1'b1, 1'b0};
    tbl[3] = '{16'hFF80, 8'd0,   4'd0,  1'b1, 1'b0};
    tbl[4] = '{16'h0C80, 8'd25,  4'd0,  1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 8'd25,  4'd0,  1'b0, 1'b1};
    tbl[6] = '{16'h0C80, 8'd25,  4'd0,  1'b1, 1'b0};

    rst = 1'b1;
    next_frame = tbl[0].frame;
    repeat (3) @(negedge clk);
    check("rst cs_n", cs_n, 1);
    check("rst sck", sck, 0);
    check("rst temp_c", temp_c, 0);
    check("rst temp_frac", temp_frac, 0);
    check("rst valid", valid, 0);
    check("rst err", err, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;
    rel = cyc;

    prev = 0;
    for (int i = 0; i < 7; i++) begin
      next_frame = tbl[i].frame;
      run_frame(tbl[i], $sformatf("v%0d", i), start);
      if (i == 0) check("first_start", start - rel, 1);
      else        check($sformatf("v%0d period", i), start - prev, SAMPLE_PERIOD);
      prev = start;
    end

    // Reset in the middle of bit 8 of a 26.0625 degC frame.
    next_frame = 16'h0D08;
    n = 0;
    while (cs_n !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    check("mid start", cs_n, 0);
    r = 0; psck = 1'b0; n = 0;
    while (r < 8 && n < BUDGET) begin
      if (sck && !psck) r++;
      psck = sck;
      if (r < 8) @(negedge clk);
      n++;
    end
    check("mid reached_bit8", r, 8);
    rst = 1'b1;
    @(negedge clk);
    check("mid cs_n", cs_n, 1);
    check("mid sck", sck, 0);
    check("mid temp_c", temp_c, 0);
    check("mid valid", valid, 0);
    check("mid busy", busy, 0);
    rst = 1'b0;
    rel = cyc;
    mid = '{16'h0D08, 8'd26, 4'd1, 1'b1, 1'b0};
    run_frame(mid, "after_rst", start);
    check("after_rst start", start - rel, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
